uart_cfg_sequencer: RTL

UART_CFG_SEQUENCER -- requirements
Module: uart_cfg_sequencer

---
 rtl/uart_cfg_sequencer_pkg.sv | 37 +++
 rtl/uart_cfg_sequencer_apb_master_if.sv | 78 +++++++
 rtl/uart_cfg_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/uart_cfg_sequencer_pkg.sv
// Shared constants for the UART configuration sequencer: register map,
// APB master state encoding and the default PREADY timeout.
package uart_cfg_sequencer_pkg;

  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

  // UART register addresses written by the configuration sequence
  localparam logic [31:0] ADDR_DLL = 32'h0000_0001;
  localparam logic [31:0] ADDR_DLH = 32'h0000_0002;
  localparam logic [31:0] ADDR_LCR = 32'h0000_0003;
  localparam logic [31:0] ADDR_IER = 32'h0000_0004;

  localparam int          CFG_WRITES   = 4;
  localparam logic [1:0]  CFG_LAST_IDX = 2'd3;

  // APB master states; the plain constants keep older code compiling
  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

  localparam logic [1:0] ST_IDLE   = APB_IDLE;
  localparam logic [1:0] ST_SETUP  = APB_SETUP;
  localparam logic [1:0] ST_ACCESS = APB_ACCESS;

  // Address of the n-th register in the configuration write order
  function automatic logic [31:0] cfg_reg_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    return ADDR_DLL;
      2'd1:    return ADDR_DLH;
      2'd2:    return ADDR_LCR;
      default: return ADDR_IER;
    endcase
  endfunction

endpackage

// File: rtl/uart_cfg_sequencer_apb_master_if.sv
// Single-transfer APB master: SETUP/ACCESS sequencing with a PREADY timeout.
// A new request may be launched from IDLE or on the completion edge of the
// current transfer, which lets the caller chain transfers back to back.
module apb_master_if
  import uart_cfg_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        idle,
  output logic        xfer_end,
  output logic        xfer_err,
  output logic [31:0] xfer_rdata,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] wait_cnt_reg;
  logic          in_access, timeout_hit, launch;

  assign idle        = (state_reg == ST_IDLE);
  assign in_access   = (state_reg == ST_ACCESS);
  // The last permitted wait cycle is the abort edge
  assign timeout_hit = in_access && !PREADY && (wait_cnt_reg == CW'(TIMEOUT_CYCLES - 1));
  assign xfer_end    = in_access && (PREADY || timeout_hit);
  assign xfer_err    = in_access && ((PREADY && PSLVERR) || timeout_hit);
  assign xfer_rdata  = PRDATA;
  assign launch      = req_valid && (idle || xfer_end);

  assign PSEL    = (state_reg != ST_IDLE);
  assign PENABLE = in_access;

  // Next-state selection for the SETUP/ACCESS handshake
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (launch) state_next = ST_SETUP;
      ST_SETUP:  state_next = ST_ACCESS;
      ST_ACCESS: if (xfer_end) state_next = launch ? ST_SETUP : ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // State, wait counter and request capture (held stable until completion)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      wait_cnt_reg <= '0;
      PWRITE       <= 1'b0;
      PADDR        <= '0;
      PWDATA       <= '0;
    end else begin
      state_reg <= state_next;
      if (in_access && !xfer_end) wait_cnt_reg <= wait_cnt_reg + CW'(1);
      else                        wait_cnt_reg <= '0;
      if (launch) begin
        PWRITE <= req_write;
        PADDR  <= req_addr;
        PWDATA <= req_wdata;
      end
    end
  end

endmodule

// File: rtl/uart_cfg_sequencer.sv
// UART configuration sequencer with host pass-through. Writes DLL, DLH, LCR
// and IER back to back over APB when cfg_start is accepted; otherwise serves
// single host transfers. The configuration sequence has priority and cannot
// be interrupted by the host once it has started.
module uart_cfg_sequencer
  import uart_cfg_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_start,
  input  logic [7:0]  cfg_dll,
  input  logic [7:0]  cfg_dlh,
  input  logic [7:0]  cfg_lcr,
  input  logic [7:0]  cfg_ier,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err,
  input  logic        host_req,
  input  logic        host_write,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_ack,
  output logic        host_err,
  output logic [31:0] host_rdata,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  logic        m_idle, xfer_end, xfer_err;
  logic [31:0] xfer_rdata;
  logic        req_valid, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        cfg_accept, cfg_chain, host_launch;
  logic        cfg_busy_reg, cfg_done_reg, cfg_err_reg;
  logic [1:0]  cfg_idx_reg, next_idx;
  logic [31:0] cfg_pack;
  logic [7:0]  cfg_in      [CFG_WRITES];
  logic [7:0]  cfg_val_reg [CFG_WRITES];
  logic        host_active_reg, host_ack_reg, host_err_reg;
  logic [31:0] host_rdata_reg;

  // Slot n of the value array holds the data for the n-th write
  assign cfg_pack = {cfg_ier, cfg_lcr, cfg_dlh, cfg_dll};
  for (genvar gi = 0; gi < CFG_WRITES; gi++) begin : g_cfg_in
    assign cfg_in[gi] = cfg_pack[8*gi +: 8];
  end

  assign next_idx    = cfg_idx_reg + 2'd1;
  assign cfg_accept  = cfg_start && m_idle && !cfg_busy_reg;
  assign cfg_chain   = cfg_busy_reg && xfer_end && !xfer_err && (cfg_idx_reg != CFG_LAST_IDX);
  // host_ack_reg blocks the IDLE cycle in which the host still holds host_req
  assign host_launch = host_req && m_idle && !cfg_busy_reg && !cfg_accept && !host_ack_reg;

  // Request selection: first config write, next config write, or host transfer
  always_comb begin
    req_valid = 1'b0;
    req_write = 1'b1;
    req_addr  = '0;
    req_wdata = '0;
    if (cfg_accept) begin
      req_valid = 1'b1;
      req_addr  = ADDR_DLL;
      req_wdata = {24'd0, cfg_dll};
    end else if (cfg_chain) begin
      req_valid = 1'b1;
      req_addr  = cfg_reg_addr(next_idx);
      req_wdata = {24'd0, cfg_val_reg[next_idx]};
    end else if (host_launch) begin
      req_valid = 1'b1;
      req_write = host_write;
      req_addr  = host_addr;
      req_wdata = host_wdata;
    end
  end

  // Configuration sequence: latch values, step the write index, report done/err
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_busy_reg <= 1'b0;
      cfg_done_reg <= 1'b0;
      cfg_err_reg  <= 1'b0;
      cfg_idx_reg  <= '0;
      for (int i = 0; i < CFG_WRITES; i++) cfg_val_reg[i] <= '0;
    end else begin
      cfg_done_reg <= 1'b0;
      if (cfg_accept) begin
        cfg_busy_reg <= 1'b1;
        cfg_err_reg  <= 1'b0;
        cfg_idx_reg  <= '0;
        for (int i = 0; i < CFG_WRITES; i++) cfg_val_reg[i] <= cfg_in[i];
      end else if (cfg_busy_reg && xfer_end) begin
        if (xfer_err || cfg_idx_reg == CFG_LAST_IDX) begin
          cfg_busy_reg <= 1'b0;
          cfg_done_reg <= 1'b1;
          if (xfer_err) cfg_err_reg <= 1'b1;
        end else begin
          cfg_idx_reg <= next_idx;
        end
      end
    end
  end

  // Host transfer tracking: ack one cycle after completion, read data on success
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_active_reg <= 1'b0;
      host_ack_reg    <= 1'b0;
      host_err_reg    <= 1'b0;
      host_rdata_reg  <= '0;
    end else begin
      host_ack_reg <= 1'b0;
      host_err_reg <= 1'b0;
      if (host_launch) begin
        host_active_reg <= 1'b1;
      end else if (host_active_reg && xfer_end) begin
        host_active_reg <= 1'b0;
        host_ack_reg    <= 1'b1;
        host_err_reg    <= xfer_err;
        if (!PWRITE && !xfer_err) host_rdata_reg <= xfer_rdata;
      end
    end
  end

  assign cfg_busy   = cfg_busy_reg;
  assign cfg_done   = cfg_done_reg;
  assign cfg_err    = cfg_err_reg;
  assign host_ack   = host_ack_reg;
  assign host_err   = host_err_reg;
  assign host_rdata = host_rdata_reg;

  apb_master_if #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_apb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .idle      (m_idle),
    .xfer_end  (xfer_end),
    .xfer_err  (xfer_err),
    .xfer_rdata(xfer_rdata),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

endmodule
